// File: rtl/bot_motion_requester.sv
// Bot-side end of the velocity handshake. It integrates position from velocity and
// requests a new velocity from the controller when the next step would leave the arena.
module bot_motion_requester #(
  parameter int          W        = 16,
  parameter int          POS_MIN  = 0,
  parameter int          POS_MAX  = 1000,
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned TIMEOUT  = 64,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          init_load,
  input  logic [W-1:0]  init_px,
  input  logic [W-1:0]  init_py,
  input  logic [W-1:0]  init_vx,
  input  logic [W-1:0]  init_vy,
  output logic          req,
  output logic [W-1:0]  req_px,
  output logic [W-1:0]  req_py,
  input  logic          wr_valid,
  input  logic [W-1:0]  wr_vx,
  input  logic [W-1:0]  wr_vy,
  output logic [W-1:0]  pos_x,
  output logic [W-1:0]  pos_y,
  output logic [W-1:0]  vel_x,
  output logic [W-1:0]  vel_y,
  output logic          moving,
  output logic          timed_out,
  output logic [CW-1:0] req_count
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic signed [W:0] PMin = (W+1)'(POS_MIN);
  localparam logic signed [W:0] PMax = (W+1)'(POS_MAX);
  localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] TmoLast  = OW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StMove, StReq} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [W-1:0]    vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [W-1:0]    req_px_q, req_px_d, req_py_q, req_py_d;
  logic            req_q, req_d;
  logic            tmo_pulse_q, tmo_pulse_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [OW-1:0]   tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic signed [W:0] nx, ny, cx, cy;
  logic              nx_in, ny_in, vel_nz, bounce;

  // Saturating two's-complement negation: the most negative value has no positive twin.
  function automatic logic [W-1:0] neg_sat(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v == {1'b1, {(W-1){1'b0}}}) r = {1'b0, {(W-1){1'b1}}};
    else                            r = -v;
    return r;
  endfunction

  // One extra bit so the candidate step cannot wrap.
  always_comb begin
    nx     = {pos_x_q[W-1], pos_x_q} + {vel_x_q[W-1], vel_x_q};
    ny     = {pos_y_q[W-1], pos_y_q} + {vel_y_q[W-1], vel_y_q};
    nx_in  = (nx >= PMin) && (nx <= PMax);
    ny_in  = (ny >= PMin) && (ny <= PMax);
    cx     = (nx < PMin) ? PMin : ((nx > PMax) ? PMax : nx);
    cy     = (ny < PMin) ? PMin : ((ny > PMax) ? PMax : ny);
    vel_nz = (vel_x_q != '0) || (vel_y_q != '0);
    bounce = !(nx_in && ny_in) && vel_nz;
  end

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    vel_x_d     = vel_x_q;
    vel_y_d     = vel_y_q;
    req_px_d    = req_px_q;
    req_py_d    = req_py_q;
    req_d       = req_q;
    tmo_pulse_d = 1'b0;
    tick_d      = tick_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;

    if (init_load) begin
      pos_x_d = init_px;
      pos_y_d = init_py;
      vel_x_d = init_vx;
      vel_y_d = init_vy;
      tick_d  = '0;
      req_d   = 1'b0;
      state_d = StMove;
    end else begin
      unique case (state_q)
        StIdle: ;
        StMove: begin
          if (en) begin
            if (tick_q == TickLast) begin
              tick_d = '0;
              if (bounce) begin
                pos_x_d  = cx[W-1:0];
                pos_y_d  = cy[W-1:0];
                req_px_d = cx[W-1:0];
                req_py_d = cy[W-1:0];
                req_d    = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                tmo_d    = '0;
                state_d  = StReq;
              end else begin
                pos_x_d = nx[W-1:0];
                pos_y_d = ny[W-1:0];
              end
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        StReq: begin
          if (wr_valid) begin
            vel_x_d = wr_vx;
            vel_y_d = wr_vy;
            req_d   = 1'b0;
            tick_d  = '0;
            state_d = StMove;
          end else if (tmo_q == TmoLast) begin
            vel_x_d     = neg_sat(vel_x_q);
            vel_y_d     = neg_sat(vel_y_q);
            tmo_pulse_d = 1'b1;
            req_d       = 1'b0;
            tick_d      = '0;
            state_d     = StMove;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      vel_x_q     <= '0;
      vel_y_q     <= '0;
      req_px_q    <= '0;
      req_py_q    <= '0;
      req_q       <= 1'b0;
      tmo_pulse_q <= 1'b0;
      tick_q      <= '0;
      tmo_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      vel_x_q     <= vel_x_d;
      vel_y_q     <= vel_y_d;
      req_px_q    <= req_px_d;
      req_py_q    <= req_py_d;
      req_q       <= req_d;
      tmo_pulse_q <= tmo_pulse_d;
      tick_q      <= tick_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req       = req_q;
  assign req_px    = req_px_q;
  assign req_py    = req_py_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign vel_x     = vel_x_q;
  assign vel_y     = vel_y_q;
  assign moving    = (state_q == StMove);
  assign timed_out = tmo_pulse_q;
  assign req_count = cnt_q;

endmodule

// File: tb/tb_bot_motion_requester.sv
// Directed bench for bot_motion_requester: stepping, bounces, timeout reversal, enable
// freeze, priority between init_load and wr_valid, and asynchronous reset.
module tb_bot_motion_requester;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b1;
  logic               init_load = 1'b0;
  logic signed [15:0] init_px = '0, init_py = '0, init_vx = '0, init_vy = '0;
  logic               wr_valid = 1'b0;
  logic signed [15:0] wr_vx = '0, wr_vy = '0;
  logic               req, moving, timed_out;
  logic signed [15:0] req_px, req_py, pos_x, pos_y, vel_x, vel_y;
  logic [15:0]        req_count;

  int tests = 0;
  int fails = 0;

  bot_motion_requester dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .init_load (init_load),
    .init_px   (init_px),
    .init_py   (init_py),
    .init_vx   (init_vx),
    .init_vy   (init_vy),
    .req       (req),
    .req_px    (req_px),
    .req_py    (req_py),
    .wr_valid  (wr_valid),
    .wr_vx     (wr_vx),
    .wr_vy     (wr_vy),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .vel_x     (vel_x),
    .vel_y     (vel_y),
    .moving    (moving),
    .timed_out (timed_out),
    .req_count (req_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_init(input int px, input int py, input int vx, input int vy);
    init_load = 1'b1;
    init_px   = 16'(px);
    init_py   = 16'(py);
    init_vx   = 16'(vx);
    init_vy   = 16'(vy);
    step(1);
    init_load = 1'b0;
  endtask

  initial begin
    // Reset values
    step(2);
    check("rst_pos_x", pos_x, 0);
    check("rst_vel_x", vel_x, 0);
    check("rst_req", req, 0);
    check("rst_moving", moving, 0);
    check("rst_count", req_count, 0);
    rst = 1'b0;
    step(1);

    // Free motion, one step every four cycles
    do_init(10, 10, 5, 3);
    check("init_moving", moving, 1);
    check("init_pos_x", pos_x, 10);
    step(3);
    check("pre_step_x", pos_x, 10);
    step(1);
    check("step1_x", pos_x, 15);
    check("step1_y", pos_y, 13);
    step(4);
    check("step2_x", pos_x, 20);
    check("step2_y", pos_y, 16);
    check("step2_req", req, 0);

    // Upper bound bounce answered by the controller
    do_init(995, 500, 10, 0);
    step(4);
    check("bnc_req", req, 1);
    check("bnc_pos_x", pos_x, 1000);
    check("bnc_req_px", req_px, 1000);
    check("bnc_req_py", req_py, 500);
    check("bnc_count", req_count, 1);
    check("bnc_moving", moving, 0);
    step(5);
    check("bnc_hold_x", pos_x, 1000);
    wr_valid = 1'b1;
    wr_vx    = -16'sd10;
    wr_vy    = 16'sd0;
    step(1);
    wr_valid = 1'b0;
    check("wr_req", req, 0);
    check("wr_vel_x", vel_x, -10);
    step(3);
    check("wr_pre_x", pos_x, 1000);
    step(1);
    check("wr_step_x", pos_x, 990);
    check("wr_step_y", pos_y, 500);

    // Lower bound clamp, then self-reversal after the timeout
    do_init(2, 2, -5, -1);
    step(4);
    check("low_req", req, 1);
    check("low_px", req_px, 0);
    check("low_py", req_py, 1);
    check("low_count", req_count, 2);
    step(63);
    check("tmo_still_req", req, 1);
    check("tmo_no_pulse", timed_out, 0);
    step(1);
    check("tmo_pulse", timed_out, 1);
    check("tmo_vel_x", vel_x, 5);
    check("tmo_vel_y", vel_y, 1);
    check("tmo_req", req, 0);
    check("tmo_moving", moving, 1);
    step(1);
    check("tmo_pulse_end", timed_out, 0);
    step(3);
    check("tmo_resume_x", pos_x, 5);
    check("tmo_resume_y", pos_y, 2);

    // wr_valid coinciding with the timeout edge wins
    do_init(995, 500, 10, 0);
    step(4);
    check("coin_req", req, 1);
    step(63);
    wr_valid = 1'b1;
    wr_vx    = -16'sd7;
    wr_vy    = 16'sd2;
    step(1);
    wr_valid = 1'b0;
    check("coin_vel_x", vel_x, -7);
    check("coin_vel_y", vel_y, 2);
    check("coin_no_pulse", timed_out, 0);
    check("coin_req_low", req, 0);
    wr_valid = 1'b1;
    wr_vx    = 16'sd99;
    step(1);
    wr_valid = 1'b0;
    check("move_wr_ign", vel_x, -7);

    // Enable low freezes the tick and position
    do_init(100, 100, 1, 1);
    en = 1'b0;
    step(10);
    check("en_frz_x", pos_x, 100);
    en = 1'b1;
    step(3);
    check("en_pre_x", pos_x, 100);
    step(1);
    check("en_step_x", pos_x, 101);

    // Landing exactly on the bound is in range
    do_init(0, 0, 1000, 0);
    step(4);
    check("edge_pos_x", pos_x, 1000);
    check("edge_req", req, 0);
    check("edge_count", req_count, 3);

    // Zero velocity at the corner never requests
    do_init(1000, 1000, 0, 0);
    step(8);
    check("zero_req", req, 0);
    check("zero_pos_y", pos_y, 1000);

    // Most negative velocity saturates on reversal
    do_init(0, 0, -32768, 0);
    step(4);
    check("sat_req", req, 1);
    step(64);
    check("sat_pulse", timed_out, 1);
    check("sat_vel_x", vel_x, 32767);
    check("sat_count", req_count, 4);

    // Asynchronous reset while requesting
    do_init(995, 500, 10, 0);
    step(4);
    check("pre_rst_req", req, 1);
    rst = 1'b1;
    #1;
    check("arst_req", req, 0);
    check("arst_pos_x", pos_x, 0);
    check("arst_moving", moving, 0);
    check("arst_count", req_count, 0);
    step(1);
    rst = 1'b0;
    step(1);

    // init_load beats wr_valid during a pending request
    do_init(995, 500, 10, 0);
    step(4);
    check("pri_req", req, 1);
    wr_valid = 1'b1;
    wr_vx    = 16'sd9;
    wr_vy    = 16'sd9;
    do_init(10, 20, 3, 4);
    wr_valid = 1'b0;
    check("pri_vel_x", vel_x, 3);
    check("pri_vel_y", vel_y, 4);
    check("pri_pos_x", pos_x, 10);
    check("pri_pos_y", pos_y, 20);
    check("pri_req_low", req, 0);
    check("pri_moving", moving, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
